// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcodes, sequencer states, field widths.
// Types and constants only; there is no logic, latency or flow control here.
package risc_pkg;

  localparam int INSTR_W    = 8;
  localparam int OPCODE_W   = 3;
  localparam int OPCODE_LSB = INSTR_W - OPCODE_W;
  localparam int DEF_ADDR_W = 5;

  localparam logic [OPCODE_W-1:0] OP_HLT = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_LDA = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_STO = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_JMP = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC mux: branch target, else PC+1 (fetch increment or taken skip), else hold; wraps mod 2^ADDR_W.
// Purely combinational, no state and no backpressure.
module fetch_pc_next #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_operand,
  input  logic              i_incr,
  input  logic              i_branch,
  input  logic              i_skip,
  input  logic              i_acc_zero,
  output logic [ADDR_W-1:0] o_pc_next
);

  logic w_take_skip;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_take_skip = i_skip & i_acc_zero;
  assign w_pc_inc    = i_pc + ADDR_W'(1);

  // Branch has priority over skip when the controller raises both.
  always_comb begin
    o_pc_next = i_pc;
    if (i_branch) begin
      o_pc_next = i_operand;
    end else if (i_incr || w_take_skip) begin
      o_pc_next = w_pc_inc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle fetch/decode/exec sequencer owning PC and IR; 3-cycle minimum instruction period.
// mem_req held until mem_ack; EXEC waits on exec_done; HALT parks until resume.
module fetch_sequencer
  import risc_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [INSTR_W-1:0]  mem_rdata,
  input  logic                mem_ack,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   operand,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic                acc_zero,
  input  logic                skip,
  input  logic                branch,
  input  logic                resume,
  output logic                halted,
  output logic [ADDR_W-1:0]   pc
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_mem_req;
  logic               r_instr_valid;
  logic               r_halted;
  logic [ADDR_W-1:0]  w_pc_next;
  logic               w_in_exec;

  assign w_in_exec = (r_state == ST_EXEC);

  fetch_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .i_pc       (r_pc),
    .i_operand  (r_ir[ADDR_W-1:0]),
    .i_incr     (r_state == ST_FETCH),
    .i_branch   (w_in_exec & branch),
    .i_skip     (w_in_exec & skip),
    .i_acc_zero (acc_zero),
    .o_pc_next  (w_pc_next)
  );

  // mem_req is a register so reset can drop it while the state already reads FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FETCH;
      r_pc          <= RST_PC;
      r_ir          <= '0;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (r_mem_req && mem_ack) begin
            r_ir          <= mem_rdata;
            r_pc          <= w_pc_next;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= ST_DECODE;
          end else begin
            r_mem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (r_ir[INSTR_W-1:OPCODE_LSB] == OP_HLT) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            r_pc      <= w_pc_next;
            r_mem_req <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (resume) begin
            r_halted  <= 1'b0;
            r_mem_req <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign opcode      = r_ir[INSTR_W-1:OPCODE_LSB];
  assign operand     = r_ir[ADDR_W-1:0];
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a scoreboard queue holds expected fetch addresses.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_req;
  logic [4:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic       instr_valid;
  logic       exec_done;
  logic       acc_zero;
  logic       skip;
  logic       branch;
  logic       resume;
  logic       halted;
  logic [4:0] pc;

  int n_assert = 0;
  int n_fail   = 0;
  int waited;
  logic [4:0] sb_q[$];
  logic [4:0] cur_addr;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(5), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .acc_zero    (acc_zero),
    .skip        (skip),
    .branch      (branch),
    .resume      (resume),
    .halted      (halted),
    .pc          (pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_timeout", {31'd0, mem_req}, 32'd1);
  endtask

  // Serve one fetch with wait_n stall cycles; ends in the DECODE cycle.
  task automatic fetch(input logic [7:0] data, input int wait_n, output int n_wait);
    logic [4:0] exp_addr;
    logic [4:0] exp_pc1;
    wait_req(n_wait);
    check("sb_nonempty", sb_q.size(), (sb_q.size() == 0) ? 32'd1 : sb_q.size());
    exp_addr = (sb_q.size() != 0) ? sb_q.pop_front() : 5'd0;
    exp_pc1  = exp_addr + 5'd1;
    cur_addr = exp_addr;
    check("mem_addr", mem_addr, exp_addr);
    for (int i = 0; i < wait_n; i++) begin
      mem_ack = 1'b0;
      @(negedge clk);
      check("req_hold", mem_req, 1);
      check("addr_hold", mem_addr, exp_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
    check("instr_valid", instr_valid, 1);
    check("opcode", opcode, data[7:5]);
    check("operand", operand, data[4:0]);
    check("req_drop", mem_req, 0);
    check("pc_inc", pc, exp_pc1);
  endtask

  // From DECODE: enter EXEC, optionally stall, then finish with the given controller outputs.
  task automatic exec(input logic b, input logic s, input logic z, input int hold, input logic [4:0] exp_next);
    @(negedge clk);
    check("ivalid_pulse", instr_valid, 0);
    for (int i = 0; i < hold; i++) begin
      exec_done = 1'b0;
      branch = 1'b1; skip = 1'b1; acc_zero = 1'b1; resume = 1'b1;
      @(negedge clk);
      check("exec_stall_req", mem_req, 0);
      check("exec_stall_pc", pc, cur_addr + 5'd1);
    end
    resume    = 1'b0;
    exec_done = 1'b1;
    branch    = b;
    skip      = s;
    acc_zero  = z;
    sb_q.push_back(exp_next);
    @(negedge clk);
    exec_done = 1'b0; branch = 1'b0; skip = 1'b0; acc_zero = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_rdata = 8'h00; mem_ack = 1'b0; exec_done = 1'b0;
    acc_zero = 1'b0; skip = 1'b0; branch = 1'b0; resume = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_ivalid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_opcode", opcode, 0);
    check("rst_operand", operand, 0);
    check("rst_pc", pc, 0);
    sb_q.push_back(5'd0);
    rst_n = 1'b1;

    fetch(8'h40, 0, waited);  check("first_req_edge", waited, 1);
    exec(0, 0, 0, 0, 5'd1);
    fetch(8'h60, 0, waited);  check("period3_a", waited, 0);
    exec(0, 0, 1, 0, 5'd2);
    fetch(8'h80, 0, waited);  check("period3_b", waited, 0);
    exec(0, 0, 0, 1, 5'd3);
    fetch(8'hF4, 0, waited);  exec(1, 0, 0, 0, 5'd20);
    fetch(8'hE5, 0, waited);  exec(1, 0, 0, 0, 5'd5);
    fetch(8'h20, 0, waited);  exec(0, 1, 1, 0, 5'd7);
    fetch(8'hE5, 0, waited);  exec(1, 1, 1, 0, 5'd5);
    fetch(8'h20, 0, waited);  exec(0, 1, 0, 0, 5'd6);
    fetch(8'hFE, 0, waited);  exec(1, 0, 0, 0, 5'd30);
    fetch(8'h20, 0, waited);  exec(0, 1, 1, 0, 5'd0);
    fetch(8'hFF, 0, waited);  exec(1, 0, 0, 0, 5'd31);
    fetch(8'h40, 0, waited);  exec(0, 0, 0, 0, 5'd0);
    fetch(8'hE9, 4, waited);  exec(1, 0, 0, 0, 5'd9);
    fetch(8'h00, 0, waited);

    @(negedge clk);
    check("hlt_halted", halted, 1);
    check("hlt_pc", pc, 10);
    check("hlt_req", mem_req, 0);
    check("hlt_ivalid", instr_valid, 0);
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1; exec_done = 1'b1; branch = 1'b1;
      @(negedge clk);
      check("park_halted", halted, 1);
      check("park_req", mem_req, 0);
      check("park_pc", pc, 10);
    end
    mem_ack = 1'b0; exec_done = 1'b0; branch = 1'b0;
    resume = 1'b1;
    sb_q.push_back(5'd10);
    @(negedge clk);
    resume = 1'b0;
    check("resume_halted", halted, 0);
    fetch(8'hEC, 0, waited);  check("resume_req", waited, 0);
    exec(1, 0, 0, 0, 5'd12);

    wait_req(waited);
    cur_addr = (sb_q.size() != 0) ? sb_q.pop_front() : 5'd0;
    check("addr_before_rst", mem_addr, cur_addr);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_req_drop", mem_req, 0);
    check("async_pc", pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(5'd0);
    fetch(8'h40, 0, waited);  check("post_rst_edge", waited, 1);
    exec(0, 0, 0, 0, 5'd1);
    wait_req(waited);
    cur_addr = (sb_q.size() != 0) ? sb_q.pop_front() : 5'd0;
    check("final_addr", mem_addr, cur_addr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
